// File: rtl/alu_sequencer_if.sv
// Bus bundle between the instruction sequencer and its environment: the
// byte input stream, the result output stream and the byte-ALU control bus.
//
// Handshake semantics (both streams): a byte transfers on a rising clock edge
// where valid and ready are both 1. A producer holding valid keeps its data
// stable until that edge; ready may be driven freely and never depends on
// anything the producer does later in the same cycle.
//
// master: the host plus ALU side (drives input bytes, output ready, ALU result).
// slave:  the sequencer side.
interface alu_seq_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_opcode;
  logic       alu_accum_source;
  logic       alu_value_source;
  logic [7:0] alu_data;
  logic [7:0] alu_result;

  modport master (
    output in_data, in_valid, out_ready, alu_result,
    input  in_ready, out_data, out_valid,
           alu_opcode, alu_accum_source, alu_value_source, alu_data
  );

  modport slave (
    input  in_data, in_valid, out_ready, alu_result,
    output in_ready, out_data, out_valid,
           alu_opcode, alu_accum_source, alu_value_source, alu_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: byte-stream instruction front-end for the byte ALU.
// Each instruction issues exactly one ALU op cycle, then the registered
// ALU result is captured and, for EMIT instructions, returned on the output.
// Optional feature macro: ALU_SEQ_STATUS_EN -- every EMIT instruction also
// issues a status read (opcode 0xF) and returns the status as a second byte.
module alu_sequencer #(
  parameter int RETIRE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_seq_if.slave            bus,
  output logic                busy,
  output logic [RETIRE_W-1:0] retired,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_IMM     = 3'd1,
    S_ISSUE   = 3'd2,
    S_RESULT  = 3'd3,
    S_EMIT    = 3'd4
`ifdef ALU_SEQ_STATUS_EN
    ,
    S_SISSUE  = 3'd5,
    S_SRESULT = 3'd6,
    S_SEMIT   = 3'd7
`endif
  } state_t;

  state_t              r_state;
  logic [7:0]          r_instr;
  logic [3:0]          r_alu_opcode;
  logic                r_alu_accum_source;
  logic                r_alu_value_source;
  logic [7:0]          r_alu_data;
  logic [7:0]          r_out_data;
  logic                r_out_valid;
  logic [RETIRE_W-1:0] r_retired;

  state_t              w_next_state;
  logic                w_in_ready;
  logic [7:0]          w_instr_d;
  logic [3:0]          w_alu_opcode_d;
  logic                w_alu_accum_source_d;
  logic                w_alu_value_source_d;
  logic [7:0]          w_alu_data_d;
  logic                w_out_load;
  logic                w_out_done;
  logic                w_retire;

  // Next-state and datapath controls; ALU bus defaults to nop so it is only
  // non-zero for the single cycle after an issue is decided.
  always_comb begin
    w_next_state         = r_state;
    w_in_ready           = 1'b0;
    w_instr_d            = r_instr;
    w_alu_opcode_d       = 4'h0;
    w_alu_accum_source_d = 1'b0;
    w_alu_value_source_d = 1'b0;
    w_alu_data_d         = 8'h00;
    w_out_load           = 1'b0;
    w_out_done           = 1'b0;
    w_retire             = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_instr_d = bus.in_data;
          if (bus.in_data[6]) begin
            w_next_state = S_IMM;
          end else begin
            w_next_state         = S_ISSUE;
            w_alu_opcode_d       = bus.in_data[3:0];
            w_alu_accum_source_d = bus.in_data[4];
            w_alu_value_source_d = bus.in_data[5];
          end
        end
      end
      S_IMM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_next_state         = S_ISSUE;
          w_alu_opcode_d       = r_instr[3:0];
          w_alu_accum_source_d = r_instr[4];
          w_alu_value_source_d = r_instr[5];
          w_alu_data_d         = bus.in_data;
        end
      end
      S_ISSUE: w_next_state = S_RESULT;
      S_RESULT: begin
        w_retire = 1'b1;
        if (r_instr[7]) begin
          w_out_load   = 1'b1;
          w_next_state = S_EMIT;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          w_out_done = 1'b1;
`ifdef ALU_SEQ_STATUS_EN
          w_next_state   = S_SISSUE;
          w_alu_opcode_d = 4'hF;
`else
          w_next_state = S_FETCH;
`endif
        end
      end
`ifdef ALU_SEQ_STATUS_EN
      S_SISSUE: w_next_state = S_SRESULT;
      S_SRESULT: begin
        w_out_load   = 1'b1;
        w_next_state = S_SEMIT;
      end
      S_SEMIT: begin
        if (bus.out_ready) begin
          w_out_done   = 1'b1;
          w_next_state = S_FETCH;
        end
      end
`endif
      default: w_next_state = S_FETCH;
    endcase
  end

  // State, instruction latch, registered ALU bus, output holding register, counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state            <= S_FETCH;
      r_instr            <= 8'h00;
      r_alu_opcode       <= 4'h0;
      r_alu_accum_source <= 1'b0;
      r_alu_value_source <= 1'b0;
      r_alu_data         <= 8'h00;
      r_out_data         <= 8'h00;
      r_out_valid        <= 1'b0;
      r_retired          <= '0;
    end else begin
      r_state            <= w_next_state;
      r_instr            <= w_instr_d;
      r_alu_opcode       <= w_alu_opcode_d;
      r_alu_accum_source <= w_alu_accum_source_d;
      r_alu_value_source <= w_alu_value_source_d;
      r_alu_data         <= w_alu_data_d;
      if (w_out_load) begin
        r_out_data  <= bus.alu_result;
        r_out_valid <= 1'b1;
      end else if (w_out_done) begin
        r_out_valid <= 1'b0;
      end
      if (w_retire) begin
        r_retired <= r_retired + RETIRE_W'(1);
      end
    end
  end

  // in_ready and busy are gated by reset so they read 0 while rst_n is low.
  assign bus.in_ready         = w_in_ready & rst_n;
  assign bus.out_data         = r_out_data;
  assign bus.out_valid        = r_out_valid;
  assign bus.alu_opcode       = r_alu_opcode;
  assign bus.alu_accum_source = r_alu_accum_source;
  assign bus.alu_value_source = r_alu_value_source;
  assign bus.alu_data         = r_alu_data;
  assign busy                 = rst_n & (r_state != S_FETCH);
  assign retired              = r_retired;
  assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a small byte-ALU model (two accumulators, flags,
// registered data_out), a vector table of programs, and hand sequences for
// back-pressure, latency, reset mid-immediate and counter wrap.
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] retired;
  logic [2:0] dbg_state;

  alu_seq_if bus ();

  alu_sequencer #(.RETIRE_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .retired     (retired),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [13:0] issue_q[$];
  logic [7:0]  exp_retired;
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ALU model ----------------
  logic [7:0] m_acc [2];
  logic       m_z, m_n;
  logic [7:0] m_a, m_v;
  logic [8:0] m_r;

  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] v);
    logic [7:0] p;
    p = a * v;
    case (op)
      4'h1:    return {1'b1, v};
      4'h2:    return {1'b1, a + v};
      4'h3:    return {1'b1, a - v};
      4'h4:    return {1'b1, a & v};
      4'h5:    return {1'b1, a | v};
      4'h6:    return {1'b1, a ^ v};
      4'hC:    return {1'b1, p};
      default: return {1'b0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_acc[0]       <= 8'h00;
      m_acc[1]       <= 8'h00;
      m_z            <= 1'b0;
      m_n            <= 1'b0;
      bus.alu_result <= 8'h00;
    end else begin
      m_a = m_acc[bus.alu_accum_source];
      m_v = bus.alu_value_source ? m_acc[!bus.alu_accum_source] : bus.alu_data;
      m_r = alu_fn(bus.alu_opcode, m_a, m_v);
      if (bus.alu_opcode == 4'hF) begin
        bus.alu_result <= {6'b0, m_n, m_z};
      end else begin
        bus.alu_result <= m_r[7:0];
        if (m_r[8]) begin
          m_acc[bus.alu_accum_source] <= m_r[7:0];
          m_n <= m_r[7];
          m_z <= (m_r[7:0] == 8'h00);
        end
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("out_unexpected", {24'h0, bus.out_data}, 32'hFFFF_FFFF);
      else chk("out_data", {24'h0, bus.out_data}, {24'h0, exp_q.pop_front()});
    end
  end

  logic [13:0] w_issue;
  assign w_issue = {bus.alu_opcode, bus.alu_accum_source, bus.alu_value_source, bus.alu_data};

  always @(negedge clk) begin
    if (mon_en && w_issue != 14'h0) begin
      if (issue_q.size() == 0) chk("issue_unexpected", {18'h0, w_issue}, 32'hFFFF_FFFF);
      else chk("issue_word", {18'h0, w_issue}, {18'h0, issue_q.pop_front()});
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        chk("in_accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Pushes expectations, then drives the instruction (and immediate if bit 6).
  task automatic send_instr(input logic [7:0] instr, input logic [7:0] imm,
                            input logic [7:0] eo, input logic [7:0] es);
    logic [7:0]  d;
    logic [13:0] iw;
    d  = instr[6] ? imm : 8'h00;
    iw = {instr[3:0], instr[4], instr[5], d};
    if (iw != 14'h0) issue_q.push_back(iw);
    if (instr[7]) begin
      exp_q.push_back(eo);
`ifdef ALU_SEQ_STATUS_EN
      issue_q.push_back({4'hF, 2'b00, 8'h00});
      exp_q.push_back(es);
`else
      if (es == 8'hEE) $display("status byte unused");
`endif
    end
    exp_retired = exp_retired + 8'd1;
    send_byte(instr);
    if (instr[6]) send_byte(imm);
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid && !busy) break;
      n++;
      if (n > 300) begin
        chk("idle_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] exp_out;
    logic [7:0] exp_status;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{8'hC1, 8'h2A, 8'h2A, 8'h00};  // load, emit
    vecs[1]  = '{8'h41, 8'h05, 8'h00, 8'h00};  // acc0 = 5
    vecs[2]  = '{8'hC2, 8'h03, 8'h08, 8'h00};  // add -> 8
    vecs[3]  = '{8'h51, 8'h07, 8'h00, 8'h00};  // acc1 = 7
    vecs[4]  = '{8'h41, 8'h06, 8'h00, 8'h00};  // acc0 = 6
    vecs[5]  = '{8'hA0, 8'h00, 8'h06, 8'h00};  // read acc0
    vecs[6]  = '{8'hAC, 8'h00, 8'h2A, 8'h00};  // acc0 *= acc1
    vecs[7]  = '{8'hC3, 8'h02, 8'h28, 8'h00};  // sub
    vecs[8]  = '{8'h90, 8'h00, 8'h07, 8'h00};  // read acc1
    vecs[9]  = '{8'hC1, 8'hFF, 8'hFF, 8'h02};  // load 0xFF, negative
    vecs[10] = '{8'h80, 8'h00, 8'hFF, 8'h02};  // read acc0
    vecs[11] = '{8'hC2, 8'h01, 8'h00, 8'h01};  // wraps to zero
    vecs[12] = '{8'h80, 8'h00, 8'h00, 8'h01};  // read accumulator

    rst_n         = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    exp_retired   = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {31'h0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rst_out_data",  {24'h0, bus.out_data}, 32'd0);
    chk("rst_alu_bus",   {18'h0, w_issue}, 32'd0);
    chk("rst_busy",      {31'h0, busy}, 32'd0);
    chk("rst_retired",   {24'h0, retired}, 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("fetch_in_ready", {31'h0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Table-driven programs
    for (int i = 0; i < 13; i++) begin
      send_instr(vecs[i].instr, vecs[i].imm, vecs[i].exp_out, vecs[i].exp_status);
    end
    wait_idle();
    chk("table_retired", {24'h0, retired}, {24'h0, exp_retired});

    // Output back-pressure: acc0 = 5, add 3 -> 0x08 held for 5 cycles
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send_instr(8'h41, 8'h05, 8'h00, 8'h00);
    send_instr(8'hC2, 8'h03, 8'h08, 8'h00);
    begin
      int n = 0;
      forever begin
        @(negedge clk);
        if (bus.out_valid) break;
        n++;
        if (n > 50) begin
          chk("bp_valid_timeout", 32'd1, 32'd0);
          break;
        end
      end
    end
    @(posedge clk); #1;
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_data",  {24'h0, bus.out_data}, 32'h08);
      chk("bp_out_valid", {31'h0, bus.out_valid}, 32'd1);
      chk("bp_in_ready",  {31'h0, bus.in_ready}, 32'd0);
      chk("bp_alu_op",    {28'h0, bus.alu_opcode}, 32'd0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    chk("bp_retired", {24'h0, retired}, {24'h0, exp_retired});

    // Reset mid-IMM: 0xC2 abandoned, then 0x80 reads a cleared acc0
    @(posedge clk); #1;
    send_byte(8'hC2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'h0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_retired = 8'd0;
    @(negedge clk);
    chk("midrst_busy",    {31'h0, busy}, 32'd0);
    chk("midrst_retired", {24'h0, retired}, 32'd0);
    @(posedge clk); #1;
    send_instr(8'h80, 8'h00, 8'h00, 8'h00);
    wait_idle();
    chk("midrst_retired_after", {24'h0, retired}, 32'd1);

    // Latency without immediate: retire and out_valid two edges after accept
    @(posedge clk); #1;
    send_instr(8'h81, 8'h00, 8'h00, 8'h01);
    @(negedge clk);
    chk("lat0_busy", {31'h0, busy}, 32'd1);
    @(negedge clk);
    chk("lat0_ret_early", {24'h0, retired}, {24'h0, exp_retired - 8'd1});
    chk("lat0_valid_early", {31'h0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("lat0_ret", {24'h0, retired}, {24'h0, exp_retired});
    chk("lat0_valid", {31'h0, bus.out_valid}, 32'd1);
    wait_idle();

    // Latency with immediate: measured from the immediate accept edge
    @(posedge clk); #1;
    send_instr(8'hC1, 8'h33, 8'h33, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("lat1_ret_early", {24'h0, retired}, {24'h0, exp_retired - 8'd1});
    @(negedge clk);
    chk("lat1_ret", {24'h0, retired}, {24'h0, exp_retired});
    wait_idle();

    // Counter wrap: random non-emit, non-immediate instructions up to 256
    @(posedge clk); #1;
    begin
      int n;
      n = 256 - int'(exp_retired);
      for (int k = 0; k < n; k++) begin
        send_instr({2'b00, 6'($urandom_range(0, 63))}, 8'h00, 8'h00, 8'h00);
      end
    end
    wait_idle();
    chk("wrap_retired", {24'h0, retired}, 32'd0);

    repeat (3) @(negedge clk);
    chk("exp_q_drained",   exp_q.size(), 32'd0);
    chk("issue_q_drained", issue_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction front-end that drives the byte ALU as its initiator. It accepts a byte stream of instructions and optional immediates over a valid/ready input. For each instruction it issues exactly one ALU operation cycle and captures the registered ALU result one cycle later. Selected results are returned over a valid/ready output, so a host can run ALU programs without cycle-exact control of the opcode lines.

## Interface
- `RETIRE_W`, default 8: width of the retired-instruction counter.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `in_data` in 8: instruction or immediate byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: sequencer accepts `in_data` this cycle.
- `out_data` out 8: result byte.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: consumer accepts `out_data`.
- `alu_opcode` out 4: to ALU `opcode`.
- `alu_accum_source` out 1: to ALU `accum_source`.
- `alu_value_source` out 1: to ALU `value_source`.
- `alu_data` out 8: to ALU `data_in`.
- `alu_result` in 8: from ALU `data_out`, which is registered.
- `busy` out 1: state is not FETCH.
- `retired` out RETIRE_W: count of completed instructions.

## Operation
- Instruction byte fields:
  - [3:0] opcode.
  - [4] accum_source.
  - [5] value_source.
  - [6] IMM: the next input byte is the immediate.
  - [7] EMIT: push the result to the output.
- States: FETCH, IMM, ISSUE, RESULT, EMIT, plus SISSUE, SRESULT, SEMIT under the macro.
- FETCH: `in_ready`=1. On handshake, latch the instruction. Go to IMM if IMM is set, else go to ISSUE with immediate 0x00.
- IMM: `in_ready`=1. On handshake, latch the immediate and go to ISSUE.
- ISSUE: lasts exactly one cycle.
  - `alu_opcode`, `alu_accum_source`, `alu_value_source` and `alu_data` carry the instruction fields and the immediate.
  - Next state is RESULT.
- All other states drive `alu_opcode`=0x0 (nop), both sources 0 and `alu_data`=0x00. Only ISSUE and SISSUE can mutate ALU state.
- RESULT: lasts one cycle. `alu_result` holds the op result.
  - `retired` increments, wrapping modulo 2^RETIRE_W.
  - If EMIT: load `out_data`←`alu_result`, set `out_valid`, go to EMIT. Otherwise go to FETCH.
- EMIT: hold `out_data` and `out_valid` stable until `out_ready`. On handshake go to FETCH, or to SISSUE under the macro.
- Opcode 0x0 with EMIT is a "read accumulator" instruction.
- All 16 opcodes are passed through unmodified. The sequencer never interprets opcodes.
- Division by zero, overflow and similar cases are entirely the ALU's concern.

## Timing
- Reset values while `rst_n`=0:
  - state FETCH.
  - `in_ready`=0, `out_valid`=0, `out_data`=0x00.
  - `alu_opcode`=0, sources 0, `alu_data`=0x00.
  - `busy`=0, `retired`=0.
- `in_ready` is forced 0 while `rst_n`=0. It is 1 in FETCH from the first cycle after release.
- `alu_*` outputs are registers. They are loaded on the edge entering ISSUE and cleared on the edge leaving it.
- ALU result appears the cycle after ISSUE and is sampled on the RESULT→next edge.
- Minimum instruction latency, accept edge to `retired` increment:
  - 2 cycles without immediate.
  - 3 cycles with immediate.
  - Throughput is 1 instruction per 3 cycles.
- With EMIT, `out_valid` rises in the cycle after RESULT.
- `in_ready`=0 throughout ISSUE, RESULT and EMIT. Back-pressure on output stalls input; it never drops or reorders results.
- `in_valid` low in IMM: wait indefinitely with nothing issued.
- Reset mid-operation:
  - Abandon the instruction and discard the pending immediate or result.
  - Return to FETCH.
  - The ALU shares `rst_n` and is cleared on the same edge.

## Configuration
- `ALU_SEQ_STATUS_EN` defined: every EMIT instruction returns two bytes, the result and then the status.
  - After the EMIT handshake, go to SISSUE: issue opcode 0xF for one cycle with sources 0 and `alu_data` 0x00.
  - SRESULT: latch `alu_result` to `out_data`.
  - SEMIT: handshake, then go to FETCH.
  - `retired` still increments once per instruction.
- Undefined: SISSUE, SRESULT and SEMIT do not exist, and each EMIT instruction returns one byte.

## Test plan
- Load with emit: send 0xC1, 0x2A → ALU sees opcode 0x1 with `alu_data` 0x2A for exactly one cycle; `out_data`=0x2A; `retired`=1.
- Add with emit: send 0x41, 0x05, then 0xC2, 0x03 → single output byte 0x08; `retired`=2; no output for the first instruction.
- Output back-pressure: hold `out_ready`=0 for 5 cycles after the 0x08 result → `out_data` stays 0x08, `in_valid` bytes are not accepted, `alu_opcode`=0 throughout.
- Accumulator-to-accumulator multiply:
  - Send 0x51, 0x07 (acc1=7), then 0x41, 0x06 (acc0=6), then 0xA0 (opcode 0x0 with EMIT, reads acc0).
  - Send 0xAC (mul, value from acc1, EMIT) → outputs 0x06, then 0x2A.
- Reset mid-IMM and counter wrap:
  - Send 0xC2, pulse `rst_n` low for 1 cycle, then send 0x80 → 0x80 is decoded as an instruction, output 0x00, `retired`=1.
  - 256 non-emit instructions with RETIRE_W=8 → `retired` wraps to 0.
- `ALU_SEQ_STATUS_EN` defined: send 0xC1, 0xFF → output bytes 0xFF, then 0x02 (negative flag); `retired`=1.
